// File: rtl/spi_regbank_pkg.sv
// rtl/spi_regbank_pkg.sv - register map and bit positions for the SPI register bank
package spi_regbank_pkg;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_CFG0      = 3'd1;
    localparam logic [2:0] ADDR_CFG1      = 3'd2;
    localparam logic [2:0] ADDR_CFG2      = 3'd3;
    localparam logic [2:0] ADDR_CFG3      = 3'd4;
    localparam logic [2:0] ADDR_EVT_FLAGS = 3'd5;
    localparam logic [2:0] ADDR_EVT_MASK  = 3'd6;
    localparam logic [2:0] ADDR_ID        = 3'd7;

    localparam int CTRL_LOCK_BIT = 7;
    localparam int CTRL_WERR_BIT = 6;

    localparam int STATUS_IRQ_BIT  = 7;
    localparam int STATUS_LOCK_BIT = 6;
    localparam int STATUS_FLAG_BIT = 5;
    localparam int STATUS_WERR_BIT = 4;

    function automatic logic is_cfg_addr(input logic [2:0] addr);
        return (addr >= ADDR_CFG0) && (addr <= ADDR_CFG3);
    endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// rtl/rising_edge_detector.sv - one-cycle pulse on a 0->1 transition of a synchronous input
module rising_edge_detector (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic d,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            prev <= 1'b0;
        end else if (ena) begin
            prev <= d;
        end
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous pin, frozen when ena is low
module sync_2ff (
    input  logic clk,
    input  logic rstb,
    input  logic ena,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else if (ena) begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_regbank.sv
// rtl/spi_regbank.sv - SPI-side register bank: lockable config, W1C event flags, mask, IRQ, ID
module spi_regbank
    import spi_regbank_pkg::*;
#(
    parameter int         ADDR_W   = 3,
    parameter int         REG_W    = 8,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic [ADDR_W-1:0]    reg_addr,
    input  logic [REG_W-1:0]     reg_wdata,
    input  logic                 reg_wdata_dv,
    output logic [REG_W-1:0]     reg_rdata,
    output logic [7:0]           status,
    input  logic [REG_W-1:0]     evt_i,
    output logic [4*REG_W-1:0]   cfg_o,
    output logic                 irq_o
);

    logic             lock;
    logic             wr_err;
    logic [REG_W-1:0] cfg_q [4];
    logic [REG_W-1:0] flags;
    logic [REG_W-1:0] mask;

    logic             wr_en;
    logic             is_cfg;
    logic             lock_set;
    logic             wr_err_set;
    logic             wr_err_clr;
    logic             cfg_wr;

    logic [REG_W-1:0] evt_sync;
    logic [REG_W-1:0] evt_rise;
    logic [REG_W-1:0] flags_clr;
    logic [REG_W-1:0] flags_nxt;
    logic [REG_W-1:0] mask_nxt;
    logic [REG_W-1:0] rd_mux;

    assign wr_en      = ena & reg_wdata_dv;
    assign is_cfg     = is_cfg_addr(reg_addr);
    assign lock_set   = wr_en & (reg_addr == ADDR_CTRL) & reg_wdata[CTRL_LOCK_BIT];
    assign wr_err_clr = wr_en & (reg_addr == ADDR_CTRL) & reg_wdata[CTRL_WERR_BIT];
    assign wr_err_set = wr_en & ((is_cfg & lock) | (reg_addr == ADDR_ID));
    assign cfg_wr     = wr_en & is_cfg & ~lock;

    // LOCK is set-only; only reset brings it back to 0
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lock   <= 1'b0;
            wr_err <= 1'b0;
        end else if (ena) begin
            if (lock_set) begin
                lock <= 1'b1;
            end
            if (wr_err_set) begin
                wr_err <= 1'b1;
            end else if (wr_err_clr) begin
                wr_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 4; i++) begin
                cfg_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            case (reg_addr)
                ADDR_CFG0: cfg_q[0] <= reg_wdata;
                ADDR_CFG1: cfg_q[1] <= reg_wdata;
                ADDR_CFG2: cfg_q[2] <= reg_wdata;
                ADDR_CFG3: cfg_q[3] <= reg_wdata;
                default:   ;
            endcase
        end
    end

    assign cfg_o = {cfg_q[3], cfg_q[2], cfg_q[1], cfg_q[0]};

    for (genvar g = 0; g < REG_W; g++) begin : g_evt
        sync_2ff u_sync (
            .clk  (clk),
            .rstb (rstb),
            .ena  (ena),
            .d    (evt_i[g]),
            .q    (evt_sync[g])
        );

        rising_edge_detector u_edge (
            .clk   (clk),
            .rstb  (rstb),
            .ena   (ena),
            .d     (evt_sync[g]),
            .pulse (evt_rise[g])
        );
    end

    // OR-ing the set pulse after the clear makes a coincident edge win over W1C
    assign flags_clr = (wr_en && reg_addr == ADDR_EVT_FLAGS) ? reg_wdata : '0;
    assign flags_nxt = (flags & ~flags_clr) | evt_rise;
    assign mask_nxt  = (wr_en && reg_addr == ADDR_EVT_MASK) ? reg_wdata : mask;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            flags <= '0;
            mask  <= '0;
            irq_o <= 1'b0;
        end else if (ena) begin
            flags <= flags_nxt;
            mask  <= mask_nxt;
            irq_o <= |(flags_nxt & mask_nxt);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_CTRL: begin
                rd_mux[CTRL_LOCK_BIT] = lock;
                rd_mux[CTRL_WERR_BIT] = wr_err;
            end
            ADDR_CFG0:      rd_mux = cfg_q[0];
            ADDR_CFG1:      rd_mux = cfg_q[1];
            ADDR_CFG2:      rd_mux = cfg_q[2];
            ADDR_CFG3:      rd_mux = cfg_q[3];
            ADDR_EVT_FLAGS: rd_mux = flags;
            ADDR_EVT_MASK:  rd_mux = mask;
            ADDR_ID:        rd_mux = REG_W'(ID_VALUE);
            default:        rd_mux = '0;
        endcase
    end

    // Sampled before this cycle's write lands, so same-cycle reads see the old value
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            reg_rdata <= '0;
        end else if (ena) begin
            reg_rdata <= rd_mux;
        end
    end

    always_comb begin
        status                  = '0;
        status[STATUS_IRQ_BIT]  = irq_o;
        status[STATUS_LOCK_BIT] = lock;
        status[STATUS_FLAG_BIT] = |flags;
        status[STATUS_WERR_BIT] = wr_err;
    end

endmodule
